// File: rtl/aes_rcon_gen.sv
// ---------------------------------------------------------------------------
// aes_rcon_gen -- AES key-schedule round-constant generator.
//
// Produces the rcon sequence for AES-128/192/256. rcon is computed
// arithmetically in GF(2^8) with polynomial 0x11B, not looked up. A load
// (kld) restarts the sequence. Each knxt advances one step until the
// terminal constant for the loaded key length is reached. The sequence
// does not wrap.
//
// Optional feature: define AES_RCON_REV_EN to support the reverse
// (decrypt-schedule) direction. Without it, dir is ignored, every load is
// forward, and the reverse datapath is not built.
//
// Parameters:
//   OUT_W      width of out (multiple of 8, >= 8)
//   RCON_BYTE  byte lane of out that carries rcon
//
// Ports:
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-high reset
//   kld      in   load / restart the sequence (wins over knxt)
//   knxt     in   advance to the next constant
//   key_len  in   2  key size sampled on kld (00=128, 01=192, 10=256,
//                    11=illegal, loads as 128 and pulses err)
//   dir      in   direction sampled on kld (0=forward, 1=reverse)
//   out      out  OUT_W  rcon in lane RCON_BYTE, all other bits zero
//   rcnt     out  4  index of the current constant
//   last     out  current constant is the terminal one
//   busy     out  loaded and not yet terminal
//   err      out  one-cycle pulse: illegal key_len load, or knxt while last
//
// State table:
//   S_IDLE | nothing loaded since reset; knxt is ignored
//   S_RUN  | sequence loaded, not at its terminal constant (busy)
//   S_TERM | terminal constant reached (last); knxt raises err
// ---------------------------------------------------------------------------
module aes_rcon_gen #(
  parameter int OUT_W     = 32,
  parameter int RCON_BYTE = OUT_W / 8 - 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             kld,
  input  logic             knxt,
  input  logic [1:0]       key_len,
  input  logic             dir,
  output logic [OUT_W-1:0] out,
  output logic [3:0]       rcnt,
  output logic             last,
  output logic             busy,
  output logic             err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_TERM = 2'd2
  } state_t;

  state_t      state, state_nx;
  logic [7:0]  rcon, rcon_nx;
  logic [3:0]  rcnt_q, rcnt_nx;
  logic [1:0]  len_q, len_nx;
  logic        err_q, err_nx;

  logic [1:0]  len_ld;
  logic        len_bad;
  logic [7:0]  rcon_step;
  logic [3:0]  rcnt_step;
  logic        step_end;

  // Number of constants in the sequence for a (legal) key length.
  function automatic logic [3:0] seq_len(input logic [1:0] len);
    case (len)
      2'b01:   seq_len = 4'd8;
      2'b10:   seq_len = 4'd7;
      default: seq_len = 4'd10;
    endcase
  endfunction

  // Multiply by x in GF(2^8) mod 0x11B.
  function automatic logic [7:0] gf_xtime(input logic [7:0] v);
    gf_xtime = {v[6:0], 1'b0} ^ (v[7] ? 8'h1B : 8'h00);
  endfunction

  assign len_bad = (key_len == 2'b11);
  assign len_ld  = len_bad ? 2'b00 : key_len;

`ifdef AES_RCON_REV_EN
  logic rev_q;

  // Divide by x in GF(2^8): exact inverse of gf_xtime.
  function automatic logic [7:0] gf_xdiv(input logic [7:0] v);
    gf_xdiv = v[0] ? (((v ^ 8'h1B) >> 1) | 8'h80) : (v >> 1);
  endfunction

  // Terminal constant of the forward sequence, i.e. the reverse start.
  function automatic logic [7:0] term_rcon(input logic [1:0] len);
    case (len)
      2'b01:   term_rcon = 8'h80;
      2'b10:   term_rcon = 8'h40;
      default: term_rcon = 8'h36;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      rev_q <= 1'b0;
    else if (kld) rev_q <= dir;
  end

  always_comb begin
    rcon_step = gf_xtime(rcon);
    rcnt_step = rcnt_q + 4'd1;
    step_end  = (rcnt_step == (seq_len(len_q) - 4'd1));
    if (rev_q) begin
      rcon_step = gf_xdiv(rcon);
      rcnt_step = rcnt_q - 4'd1;
      step_end  = (rcnt_q == 4'd1);
    end
  end
`else
  logic unused_dir;
  assign unused_dir = dir;

  always_comb begin
    rcon_step = gf_xtime(rcon);
    rcnt_step = rcnt_q + 4'd1;
    step_end  = (rcnt_step == (seq_len(len_q) - 4'd1));
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      rcon   <= 8'h00;
      rcnt_q <= 4'd0;
      len_q  <= 2'b00;
      err_q  <= 1'b0;
    end else begin
      state  <= state_nx;
      rcon   <= rcon_nx;
      rcnt_q <= rcnt_nx;
      len_q  <= len_nx;
      err_q  <= err_nx;
    end
  end

  always_comb begin
    state_nx = state;
    rcon_nx  = rcon;
    rcnt_nx  = rcnt_q;
    len_nx   = len_q;
    err_nx   = 1'b0;

    if (kld) begin
      // Shortest sequence is 7, so a load never lands on the terminal.
      len_nx   = len_ld;
      err_nx   = len_bad;
      state_nx = S_RUN;
      rcon_nx  = 8'h01;
      rcnt_nx  = 4'd0;
`ifdef AES_RCON_REV_EN
      if (dir) begin
        rcon_nx = term_rcon(len_ld);
        rcnt_nx = seq_len(len_ld) - 4'd1;
      end
`endif
    end else if (knxt) begin
      case (state)
        S_RUN: begin
          rcon_nx = rcon_step;
          rcnt_nx = rcnt_step;
          if (step_end) state_nx = S_TERM;
        end
        S_TERM:  err_nx = 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    out = '0;
    out[RCON_BYTE*8 +: 8] = rcon;
  end

  assign rcnt = rcnt_q;
  assign last = (state == S_TERM);
  assign busy = (state == S_RUN);
  assign err  = err_q;

endmodule

// File: tb/tb_aes_rcon_gen.sv
module tb_aes_rcon_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        kld, knxt, dir;
  logic [1:0]  key_len;
  logic [31:0] out;
  logic [3:0]  rcnt;
  logic        last, busy, err;
  logic [7:0]  out8;
  logic [3:0]  rcnt8;
  logic        last8, busy8, err8;

  aes_rcon_gen dut (
    .clk(clk), .rst(rst), .kld(kld), .knxt(knxt), .key_len(key_len), .dir(dir),
    .out(out), .rcnt(rcnt), .last(last), .busy(busy), .err(err)
  );

  aes_rcon_gen #(.OUT_W(8), .RCON_BYTE(0)) dut8 (
    .clk(clk), .rst(rst), .kld(kld), .knxt(knxt), .key_len(key_len), .dir(dir),
    .out(out8), .rcnt(rcnt8), .last(last8), .busy(busy8), .err(err8)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] rc;
    logic [3:0] cnt;
    logic       l, b, e;
    string      tag;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  event chk_now;

  logic [7:0] fwd [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                           8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};

  task automatic chk(input string nm, input string fld, input logic [31:0] act,
                     input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s.%s: got %0h, expected %0h", nm, fld, act, req);
    end
  endtask

  task automatic push(input logic [7:0] rc, input logic [3:0] cnt,
                      input logic l, input logic b, input logic e, input string tag);
    exp_t x;
    x.rc = rc; x.cnt = cnt; x.l = l; x.b = b; x.e = e; x.tag = tag;
    q.push_back(x);
  endtask

  // One cycle of stimulus; the expected state after the sampling edge is
  // queued for the monitor.
  task automatic op(input logic ld, input logic nx, input logic [1:0] kl, input logic d,
                    input logic [7:0] rc, input logic [3:0] cnt,
                    input logic l, input logic b, input logic e, input string tag);
    @(negedge clk);
    #1;
    kld = ld; knxt = nx; key_len = kl; dir = d;
    @(posedge clk);
    #1;
    kld = 1'b0; knxt = 1'b0;
    push(rc, cnt, l, b, e, tag);
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(negedge clk or chk_now);
      if (q.size() > 0) begin
        x = q.pop_front();
        chk(x.tag, "out",   out,          {x.rc, 24'h0});
        chk(x.tag, "rcnt",  32'(rcnt),    32'(x.cnt));
        chk(x.tag, "last",  32'(last),    32'(x.l));
        chk(x.tag, "busy",  32'(busy),    32'(x.b));
        chk(x.tag, "err",   32'(err),     32'(x.e));
        chk(x.tag, "out8",  32'(out8),    32'(x.rc));
        chk(x.tag, "last8", 32'(last8),   32'(x.l));
      end
    end
  end

  initial begin : stim
    rst = 1'b1; kld = 1'b0; knxt = 1'b0; key_len = 2'b00; dir = 1'b0;
    push(8'h00, 4'd0, 1'b0, 1'b0, 1'b0, "reset");
    @(negedge clk);
    #2 rst = 1'b0;

    op(0, 1, 2'b00, 0, 8'h00, 4'd0, 0, 0, 0, "nxt_unloaded");

    // AES-128 forward, then knxt at the terminal constant.
    op(1, 0, 2'b00, 0, 8'h01, 4'd0, 0, 1, 0, "ld128");
    for (int i = 1; i < 10; i++)
      op(0, 1, 2'b00, 0, fwd[i], 4'(i), i == 9, i != 9, 0, "fwd128");
    op(0, 1, 2'b00, 0, 8'h36, 4'd9, 1, 0, 1, "nxt_at_last");
    op(0, 0, 2'b00, 0, 8'h36, 4'd9, 1, 0, 0, "err_clear");

`ifdef AES_RCON_REV_EN
    op(1, 0, 2'b00, 1, 8'h36, 4'd9, 0, 1, 0, "ld128_rev");
    for (int i = 8; i >= 0; i--)
      op(0, 1, 2'b00, 0, fwd[i], 4'(i), i == 0, i != 0, 0, "rev128");
    op(0, 1, 2'b00, 0, 8'h01, 4'd0, 1, 0, 1, "rev_nxt_at_last");
`else
    op(1, 0, 2'b00, 1, 8'h01, 4'd0, 0, 1, 0, "ld_dir_ignored");
    op(0, 1, 2'b00, 1, 8'h02, 4'd1, 0, 1, 0, "dir_ignored_step");
`endif

    // AES-256 forward; key_len/dir wiggle between loads must not matter.
    op(1, 0, 2'b10, 0, 8'h01, 4'd0, 0, 1, 0, "ld256");
    for (int i = 1; i < 7; i++)
      op(0, 1, 2'b00, 1, fwd[i], 4'(i), i == 6, i != 6, 0, "fwd256");
    op(0, 1, 2'b01, 1, 8'h40, 4'd6, 1, 0, 1, "nxt_at_last256");

`ifdef AES_RCON_REV_EN
    op(1, 0, 2'b01, 1, 8'h80, 4'd7, 0, 1, 0, "ld192_rev");
    op(0, 1, 2'b00, 0, 8'h40, 4'd6, 0, 1, 0, "rev192");
`else
    op(1, 0, 2'b01, 1, 8'h01, 4'd0, 0, 1, 0, "ld192");
    for (int i = 1; i < 8; i++)
      op(0, 1, 2'b00, 0, fwd[i], 4'(i), i == 7, i != 7, 0, "fwd192");
`endif

    // kld wins over knxt mid-sequence.
    op(1, 0, 2'b00, 0, 8'h01, 4'd0, 0, 1, 0, "ld_mid");
    for (int i = 1; i < 4; i++)
      op(0, 1, 2'b00, 0, fwd[i], 4'(i), 0, 1, 0, "fwd_mid");
    op(1, 1, 2'b00, 0, 8'h01, 4'd0, 0, 1, 0, "kld_prio");

    // Illegal key length loads as AES-128 with an err pulse.
    op(1, 0, 2'b11, 0, 8'h01, 4'd0, 0, 1, 1, "ld_illegal");
    for (int i = 1; i < 10; i++)
      op(0, 1, 2'b11, 0, fwd[i], 4'(i), i == 9, i != 9, 0, "illegal_as128");

    // Asynchronous reset mid-sequence, checked before any clock edge.
    op(1, 0, 2'b00, 0, 8'h01, 4'd0, 0, 1, 0, "ld_pre_rst");
    op(0, 1, 2'b00, 0, 8'h02, 4'd1, 0, 1, 0, "fwd_pre_rst");
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    push(8'h00, 4'd0, 0, 0, 0, "async_rst");
    ->chk_now;
    @(negedge clk);
    #1 rst = 1'b0;
    op(0, 1, 2'b00, 0, 8'h00, 4'd0, 0, 0, 0, "nxt_after_rst");
    op(1, 0, 2'b00, 0, 8'h01, 4'd0, 0, 1, 0, "ld_after_rst");

    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
